dff_bank_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit D flip-flop bank (d_ff instances, external) between NREQ requesters. Each granted requester issues one operation: write, clear, preset or read. The controller sequences the bank's d/reset/preset inputs for one cycle, then reads back q and acknowledges. It sits between the requesting agents and the d_ff bank in the flip-flop test environment.

---
 rtl/dff_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin sharing of one external d_ff bank among NREQ requesters: IDLE -> EXEC -> CHECK.
// Optional readback comparison enabled by DFF_BANK_ARBITER_READBACK_CHECK_EN.
module dff_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [2*NREQ-1:0]       op,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   output logic                    done,
   output logic [WIDTH-1:0]        rdata,
   output logic                    err,
   output logic [WIDTH-1:0]        ff_d,
   output logic                    ff_reset,
   output logic                    ff_preset,
   input  logic [WIDTH-1:0]        ff_q
);

   localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned N  = NREQ;

   typedef enum logic [1:0] {IDLE, EXEC, CHECK} state_t;
   typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_CLEAR = 2'b01,
                             OP_PRESET = 2'b10, OP_READ = 2'b11} op_t;

   state_t            state;
   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     win_idx;

   logic [1:0]        op_a [NREQ];
   logic [WIDTH-1:0]  wd_a [NREQ];

   logic              found;
   logic [IW-1:0]     sel_idx;
   logic [NREQ-1:0]   sel_onehot;
   op_t               sel_op;
   logic [WIDTH-1:0]  sel_data;
   logic [WIDTH-1:0]  nxt_d;

   for (genvar g = 0; g < NREQ; g++) begin : g_split
      assign op_a[g] = op[2*g +: 2];
      assign wd_a[g] = wdata[WIDTH*g +: WIDTH];
   end

   // First requester after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      int unsigned   k;
      logic [IW-1:0] kk;
      found      = 1'b0;
      sel_idx    = '0;
      sel_onehot = '0;
      sel_op     = OP_WRITE;
      sel_data   = '0;
      k          = 0;
      kk         = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         k  = (32'(rr_ptr) + i) % N;
         kk = IW'(k);
         if (!found && req[kk]) begin
            found           = 1'b1;
            sel_idx         = kk;
            sel_onehot      = '0;
            sel_onehot[kk]  = 1'b1;
            sel_op          = op_t'(op_a[kk]);
            sel_data        = wd_a[kk];
         end
      end
   end

   // Bank d value for the selected op; also the value expected back from the bank.
   always_comb begin
      nxt_d = '0;
      case (sel_op)
         OP_WRITE:  nxt_d = sel_data;
         OP_CLEAR:  nxt_d = '0;
         OP_PRESET: nxt_d = '1;
         OP_READ:   nxt_d = ff_q;
         default:   nxt_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= IW'(NREQ - 1);
         win_idx   <= '0;
         gnt       <= '0;
         done      <= 1'b0;
         rdata     <= '0;
         ff_d      <= '0;
         ff_reset  <= 1'b0;
         ff_preset <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               gnt  <= '0;
               done <= 1'b0;
               if (found) begin
                  win_idx   <= sel_idx;
                  gnt       <= sel_onehot;
                  ff_d      <= nxt_d;
                  ff_reset  <= (sel_op == OP_CLEAR);
                  ff_preset <= (sel_op == OP_PRESET);
                  state     <= EXEC;
               end
            end
            EXEC: begin
               done      <= 1'b1;
               rdata     <= ff_q;
               ff_reset  <= 1'b0;
               ff_preset <= 1'b0;
               state     <= CHECK;
            end
            CHECK: begin
               done   <= 1'b0;
               gnt    <= '0;
               rr_ptr <= win_idx;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DFF_BANK_ARBITER_READBACK_CHECK_EN
   logic [WIDTH-1:0] exp_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_val <= '0;
         err     <= 1'b0;
      end else begin
         if (state == IDLE && found)
            exp_val <= nxt_d;
         err <= (state == EXEC) && (ff_q != exp_val);
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: table vectors, hand sequences and random traffic vs a transaction model.
// The bank is modelled as negedge-clocked flops with asynchronous reset/preset.
module tb_dff_bank_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [2*N-1:0]   op;
   logic [N*W-1:0]   wdata;
   logic [N-1:0]     gnt;
   logic             done;
   logic [W-1:0]     rdata;
   logic             err;
   logic [W-1:0]     ff_d;
   logic             ff_reset;
   logic             ff_preset;
   logic [W-1:0]     ff_q;
   logic [W-1:0]     bank;
   logic             force_zero;

   int checks;
   int errors;

   int       last;
   logic [W-1:0] mbank;
   bit       mvalid;

   dff_bank_arbiter #(.NREQ(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
      .gnt(gnt), .done(done), .rdata(rdata), .err(err),
      .ff_d(ff_d), .ff_reset(ff_reset), .ff_preset(ff_preset), .ff_q(ff_q)
   );

   always #5 clk = ~clk;

   always @(negedge clk or posedge ff_reset or posedge ff_preset) begin
      if (ff_reset)       bank <= '0;
      else if (ff_preset) bank <= '1;
      else                bank <= ff_d;
   end

   assign ff_q = force_zero ? '0 : bank;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One complete transaction; called just after a rising edge with the DUT in IDLE.
   task automatic txn(input logic [N-1:0] r, input logic [2*N-1:0] o, input logic [N*W-1:0] w,
                      input bit drop, output logic [N-1:0] g_obs, output logic [W-1:0] rd_obs);
      int           win;
      logic [1:0]   mop;
      logic [W-1:0] md, expv, rexp;
      logic [N-1:0] eg;
      logic         eerr;
      bit           known;
      win = -1;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (win < 0 && r[idx]) win = idx;
      end
      mop = 2'(o >> (2*win));
      md  = W'(w >> (W*win));
      case (mop)
         2'd0: expv = md;
         2'd1: expv = '0;
         2'd2: expv = '1;
         default: expv = mbank;
      endcase
      known = (mop != 2'd3) || mvalid;
      eg    = N'(1) << win;
      rexp  = force_zero ? '0 : expv;
`ifdef DFF_BANK_ARBITER_READBACK_CHECK_EN
      eerr = force_zero && (expv != '0);
`else
      eerr = 1'b0;
`endif
      req = r; op = o; wdata = w;
      @(posedge clk); #2;
      chk("exec_gnt", gnt, eg);
      chk("exec_done", done, 0);
      if (known) chk("exec_ff_d", ff_d, expv);
      chk("exec_ff_reset", ff_reset, mop == 2'd1);
      chk("exec_ff_preset", ff_preset, mop == 2'd2);
      chk("exec_no_overlap", ff_reset & ff_preset, 0);
      op = ~o; wdata = ~w;
      if (drop) req = '0;
      @(posedge clk); #2;
      chk("check_gnt", gnt, eg);
      chk("check_done", done, 1);
      if (known) chk("check_rdata", rdata, rexp);
      chk("check_err", err, eerr);
      chk("check_pulses_low", {ff_reset, ff_preset}, 0);
      if (known) chk("check_ff_d", ff_d, expv);
      g_obs = gnt; rd_obs = rdata;
      @(posedge clk); #1;
      chk("idle_done", done, 0);
      chk("idle_gnt", gnt, 0);
      if (known) chk("idle_rdata_held", rdata, rexp);
      last  = win;
      mbank = expv;
      if (mop != 2'd3) mvalid = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      last = N - 1;
      mvalid = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0]   r;
      logic [2*N-1:0] o;
      logic [N*W-1:0] w;
      logic [N-1:0]   g;
      logic [W-1:0]   rd;
   } vec_t;

   vec_t vt[14];

   initial begin
      logic [N-1:0] g;
      logic [W-1:0] rd;
      logic [N-1:0] ord_g [5];
      logic [W-1:0] ord_d [5];
      checks = 0; errors = 0;
      force_zero = 1'b0;
      req = '0; op = '0; wdata = '0;
      last = N - 1; mvalid = 1'b0; mbank = '0;

      vt[0]  = '{4'b0001, 8'h00, 32'h000000A5, 4'b0001, 8'hA5};
      vt[1]  = '{4'b0001, 8'h01, 32'h00000000, 4'b0001, 8'h00};
      vt[2]  = '{4'b0001, 8'h02, 32'h00000000, 4'b0001, 8'hFF};
      vt[3]  = '{4'b0001, 8'h00, 32'h0000003C, 4'b0001, 8'h3C};
      vt[4]  = '{4'b0001, 8'h03, 32'h00000000, 4'b0001, 8'h3C};
      vt[5]  = '{4'b1111, 8'h00, 32'h44332211, 4'b0010, 8'h22};
      vt[6]  = '{4'b1111, 8'h00, 32'h44332211, 4'b0100, 8'h33};
      vt[7]  = '{4'b1111, 8'h00, 32'h44332211, 4'b1000, 8'h44};
      vt[8]  = '{4'b1111, 8'h00, 32'h44332211, 4'b0001, 8'h11};
      vt[9]  = '{4'b1010, 8'hC0, 32'h44332211, 4'b0010, 8'h22};
      vt[10] = '{4'b1010, 8'hC0, 32'h44332211, 4'b1000, 8'h22};
      vt[11] = '{4'b0100, 8'h20, 32'h44332211, 4'b0100, 8'hFF};
      vt[12] = '{4'b0011, 8'h04, 32'h44332211, 4'b0001, 8'h11};
      vt[13] = '{4'b0011, 8'h04, 32'h44332211, 4'b0010, 8'h00};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_ff_d", ff_d, 0);
      chk("rst_ff_reset", ff_reset, 0);
      chk("rst_ff_preset", ff_preset, 0);
      reset = 1'b0;

      foreach (vt[i]) begin
         txn(vt[i].r, vt[i].o, vt[i].w, 1'b0, g, rd);
         chk($sformatf("tbl%0d_gnt", i), g, vt[i].g);
         chk($sformatf("tbl%0d_rdata", i), rd, vt[i].rd);
      end

      // Grant order from reset with every requester asking.
      ord_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      ord_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1};
      req = '0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         txn(4'b1111, 8'h00, 32'hD4C3B2A1, 1'b0, g, rd);
         chk($sformatf("order%0d_gnt", k), g, ord_g[k]);
         chk($sformatf("order%0d_rdata", k), rd, ord_d[k]);
      end

      // Leave rr_ptr at 1, then abort a write with reset during EXEC.
      txn(4'b0010, 8'h00, 32'h00005500, 1'b0, g, rd);
      req = 4'b0001; op = 8'h00; wdata = 32'h00000077;
      @(posedge clk); #2;
      chk("abort_pre_gnt", gnt, 4'b0001);
      chk("abort_pre_ff_d", ff_d, 8'h77);
      reset = 1'b1;
      #1;
      chk("abort_gnt", gnt, 0);
      chk("abort_done", done, 0);
      chk("abort_ff_d", ff_d, 0);
      chk("abort_pulses", {ff_reset, ff_preset}, 0);
      @(posedge clk); #2;
      chk("abort_no_done", done, 0);
      req = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      last = N - 1; mvalid = 1'b0;
      txn(4'b0110, 8'h00, 32'h00009900, 1'b0, g, rd);
      chk("post_reset_gnt", g, 4'b0010);

      // Bank reads back zero on a write of 81.
      force_zero = 1'b1;
      txn(4'b0001, 8'h00, 32'h00000081, 1'b0, g, rd);
      force_zero = 1'b0;

      for (int n = 0; n < 120; n++) begin
         logic [N-1:0] r;
         r = N'($urandom_range(1, (1 << N) - 1));
         txn(r, 8'($urandom), $urandom, 1'($urandom_range(0, 1)), g, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
